// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   ps_state_t : occupancy state of a stage (EMPTY / HALF / FULL), encoded
//                so that the state value equals the number of held entries.
//   *_W        : payload widths of the individual core stage bundles. Narrower
//                bundles are zero-padded up to PS_WIDTH when carried.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_t;

  // pc + instr
  localparam int unsigned IFID_W  = 32 + 32;
  // pc + instr + rs1 + rs2 + imm + rd + control
  localparam int unsigned IDEX_W  = 32 + 32 + 32 + 32 + 32 + 5 + 11;
  // pc + alu result + store data + rd + control
  localparam int unsigned EXMEM_W = 32 + 32 + 32 + 5 + 8;
  // result + rd + control
  localparam int unsigned MEMWB_W = 32 + 5 + 4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Widest stage bundle; every stage instance can use this as its WIDTH.
  localparam int unsigned PS_WIDTH = max4(IFID_W, IDEX_W, EXMEM_W, MEMWB_W);

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry
// skid buffer. Latency 1 cycle, throughput 1 transfer/cycle.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating
// stall/bubble performance counters (and the CNT_W parameter and ports).
//
// Ports
//   clk           core clock, all state updates on posedge
//   reset         synchronous, active-low reset
//   in_valid      upstream presents in_payload
//   in_ready      stage can accept (function of state only)
//   in_payload    upstream payload, WIDTH bits
//   flush         discard all held entries and any payload accepted this cycle
//   out_valid     out_payload is valid
//   out_ready     downstream accepts out_payload this cycle
//   out_payload   oldest held payload
//   occupancy     number of held entries (0..2)
//   stall_cycles  [PIPE_STAGE_PERF_EN] cycles with out_valid=1, out_ready=0
//   bubble_cycles [PIPE_STAGE_PERF_EN] cycles with out_valid=0
//
// state    | meaning
// PS_EMPTY | nothing held
// PS_HALF  | one entry in main_q
// PS_FULL  | main_q holds oldest, skid_q holds the younger entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PS_WIDTH
`ifdef PIPE_STAGE_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0]   bubble_cycles
`endif
);

  ps_state_t        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  // The state encoding equals the entry count.
  assign occupancy   = state_q;
  assign out_valid   = (state_q != PS_EMPTY);
  assign in_ready    = (state_q != PS_FULL);
  assign out_payload = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Whatever was accepted this cycle is dropped; payload registers keep
      // their stale contents since out_valid masks them.
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_HALF;
            main_d  = in_payload;
          end
        end
        PS_HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_payload;
          end else if (in_fire) begin
            state_d = PS_FULL;
            skid_d  = in_payload;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_d = PS_HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (!out_valid && (bubble_q != '1))             bubble_q <= bubble_q + 1'b1;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. A payload queue is the reference:
// accepted payloads are pushed, delivered payloads popped, flush empties it.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = 176;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_payload;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_payload;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]  stall_cycles, bubble_cycles;
  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_payload;
  logic [1:0]   s_occupancy;
  logic [1:0]   s_stall, s_bubble;

  pipe_stage_reg #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_payload(out_payload), .occupancy(occupancy),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles));

  pipe_stage_reg #(.WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_payload(in_payload), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_payload(s_out_payload), .occupancy(s_occupancy),
    .stall_cycles(s_stall), .bubble_cycles(s_bubble));
`else
  pipe_stage_reg #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_payload(out_payload), .occupancy(occupancy));
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];
  int           stall_m = 0;
  int           bubble_m = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit ir, ov, inf, outf;
    in_valid   = v;
    in_payload = d;
    out_ready  = ordy;
    flush      = fl;
    #1;
    ir = (sb.size() < 2);
    ov = (sb.size() != 0);
    chk("in_ready", W'(in_ready), W'(ir));
    chk("out_valid", W'(out_valid), W'(ov));
    chk("occupancy", W'(occupancy), W'(sb.size()));
    if (ov) chk("out_payload", out_payload, sb[0]);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cycles", W'(stall_cycles), W'(sat(stall_m, 65535)));
    chk("bubble_cycles", W'(bubble_cycles), W'(sat(bubble_m, 65535)));
    chk("sat_stall", W'(s_stall), W'(sat(stall_m, 3)));
    chk("sat_bubble", W'(s_bubble), W'(sat(bubble_m, 3)));
`endif
    inf  = v & ir;
    outf = ov & ordy;
    if (ov && !ordy) stall_m++;
    if (!ov) bubble_m++;
    @(posedge clk);
    if (outf) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (inf) sb.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    in_valid   = 1'b1;
    in_payload = W'('h55);
    out_ready  = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    stall_m  = 0;
    bubble_m = 0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_payload = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Reset with in_valid asserted
    do_reset();
    #1;
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_payload", out_payload, '0);
    @(negedge clk);

    // Streaming 1..8 with out_ready held high
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall / skid, then drain
    cycle(1'b1, W'('hA), 1'b0, 1'b0);
    cycle(1'b1, W'('hB), 1'b0, 1'b0);
    cycle(1'b1, W'('hEE), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush from FULL with a payload offered in the flush cycle
    cycle(1'b1, W'('hA), 1'b0, 1'b0);
    cycle(1'b1, W'('hB), 1'b0, 1'b0);
    cycle(1'b1, W'('hC), 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    // Flush from HALF accepting 0xC while delivering the held entry
    cycle(1'b1, W'('hD0), 1'b0, 1'b0);
    cycle(1'b1, W'('hC), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous events in HALF and FULL
    cycle(1'b1, W'('hD), 1'b0, 1'b0);
    cycle(1'b1, W'('hE), 1'b1, 1'b0);
    cycle(1'b1, W'('hF), 1'b0, 1'b0);
    cycle(1'b1, W'('h99), 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Mixed traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), W'(i + 'h100), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-transfer
    cycle(1'b1, W'('h31), 1'b0, 1'b0);
    cycle(1'b1, W'('h32), 1'b0, 1'b0);
    do_reset();
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    cycle(1'b1, W'('h77), 1'b0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("stall_eq_5", W'(stall_cycles), W'(5));
    checks++;
    assert (bubble_cycles >= 16'd3) else begin
      errors++;
      $error("FAIL bubble_ge_3: observed %0d expected >= 3", bubble_cycles);
    end
    @(negedge clk);
    cycle(1'b1, W'('h78), 1'b0, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("stall_saturated", W'(s_stall), W'(3));
    chk("stall_wide_13", W'(stall_cycles), W'(13));
    @(negedge clk);
    cycle(1'b1, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
